// File: rtl/vx_mem_access_stage.sv
// SIMT memory stage: serialises per-lane loads/stores to the dcache
// ports: ex/mem bundle in, mem/wb bundle out, dcache req/rsp, freeze
module vx_mem_access_stage #(
  parameter int NT = 4,
  parameter int NW = 8,
  parameter int WW = $clog2(NW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NT*32-1:0] in_alu_result,
  input  logic [NT*32-1:0] in_rs2_data,
  input  logic [2:0]       in_mem_read,
  input  logic [2:0]       in_mem_write,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [1:0]       in_wb,
  input  logic [31:0]      in_PC_next,
  input  logic [NT-1:0]    in_valid,
  input  logic [WW-1:0]    in_warp_num,
  input  logic             in_freeze,
  output logic             dcache_req_valid,
  input  logic             dcache_req_ready,
  output logic [31:0]      dcache_req_addr,
  output logic             dcache_req_we,
  output logic [3:0]       dcache_req_byteen,
  output logic [31:0]      dcache_req_wdata,
  input  logic             dcache_rsp_valid,
  input  logic [31:0]      dcache_rsp_data,
  output logic [NT*32-1:0] out_alu_result,
  output logic [4:0]       out_rd,
  output logic [1:0]       out_wb,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_PC_next,
  output logic [NT-1:0]    out_valid,
  output logic [WW-1:0]    out_warp_num,
  output logic [NT*32-1:0] out_mem_result,
  output logic             out_freeze
);

  localparam int LW = (NT > 1) ? $clog2(NT) : 1;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t           state;
  logic [NT-1:0]    remaining;
  logic [NT*32-1:0] mem_result_q;

  logic          is_load;
  logic          is_store;
  logic          memop;
  logic          start;
  logic [LW-1:0] lane;
  logic [NT-1:0] rem_next;
  logic [31:0]   addr;
  logic [31:0]   sdata;
  logic [31:0]   byte_sh;
  logic [31:0]   half_sh;
  logic [31:0]   ld_data;

  assign is_load  = in_mem_read != 3'd7;
  assign is_store = !is_load && (in_mem_write != 3'd7);
  assign memop    = is_load || is_store;
  assign start    = memop && (|in_valid);

  // lowest set bit of remaining selects the lane being served
  always_comb begin
    lane = '0;
    for (int i = NT - 1; i >= 0; i--)
      if (remaining[i]) lane = i[LW-1:0];
  end

  // clears the lowest set bit, i.e. the current lane
  assign rem_next = remaining & (remaining - 1'b1);

  assign addr  = in_alu_result[lane*32 +: 32];
  assign sdata = in_rs2_data[lane*32 +: 32];

  always_comb begin
    dcache_req_valid  = 1'b0;
    dcache_req_addr   = '0;
    dcache_req_we     = 1'b0;
    dcache_req_byteen = '0;
    dcache_req_wdata  = '0;
    if (state == REQ) begin
      dcache_req_valid = 1'b1;
      dcache_req_addr  = {addr[31:2], 2'b00};
      if (is_load) begin
        dcache_req_byteen = 4'hf;
      end else begin
        dcache_req_we = 1'b1;
        unique case (1'b1)
          in_mem_write == 3'd0: begin
            dcache_req_wdata  = {4{sdata[7:0]}};
            dcache_req_byteen = 4'b0001 << addr[1:0];
          end
          in_mem_write == 3'd1: begin
            dcache_req_wdata  = {2{sdata[15:0]}};
            dcache_req_byteen = addr[1] ? 4'b1100
                                        : 4'b0011;
          end
          default: begin
            dcache_req_wdata  = sdata;
            dcache_req_byteen = 4'hf;
          end
        endcase
      end
    end
  end

  always_comb begin
    byte_sh = dcache_rsp_data >> {addr[1:0], 3'b000};
    half_sh = dcache_rsp_data >> {addr[1], 4'b0000};
    unique case (1'b1)
      in_mem_read == 3'd0:
        ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      in_mem_read == 3'd4:
        ld_data = {24'd0, byte_sh[7:0]};
      in_mem_read == 3'd1:
        ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      in_mem_read == 3'd5:
        ld_data = {16'd0, half_sh[15:0]};
      default:
        ld_data = dcache_rsp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      mem_result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining    <= in_valid;
            mem_result_q <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          if (dcache_req_ready) begin
            if (is_load) begin
              state <= WAIT;
            end else begin
              remaining <= rem_next;
              state     <= (rem_next == '0) ? DONE : REQ;
            end
          end
        end
        WAIT: begin
          if (dcache_rsp_valid) begin
            mem_result_q[lane*32 +: 32] <= ld_data;
            remaining <= rem_next;
            state     <= (rem_next == '0) ? DONE : REQ;
          end
        end
        DONE: begin
          if (!in_freeze) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_freeze = in_freeze
                    | ((state == IDLE) & start)
                    | (state == REQ)
                    | (state == WAIT);

  assign out_mem_result = (state == DONE) ? mem_result_q
                                          : '0;

  assign out_alu_result = in_alu_result;
  assign out_rd         = in_rd;
  assign out_wb         = in_wb;
  assign out_rs1        = in_rs1;
  assign out_rs2        = in_rs2;
  assign out_PC_next    = in_PC_next;
  assign out_valid      = in_valid;
  assign out_warp_num   = in_warp_num;

endmodule

// File: tb/tb_vx_mem_access_stage.sv
// Bench for vx_mem_access_stage: request and result scoreboards
// with a small dcache model answering loads after a set latency
module tb_vx_mem_access_stage;

  localparam int NT = 4;
  localparam int NW = 8;
  localparam int WW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NT*32-1:0] in_alu_result;
  logic [NT*32-1:0] in_rs2_data;
  logic [2:0]       in_mem_read;
  logic [2:0]       in_mem_write;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [1:0]       in_wb;
  logic [31:0]      in_PC_next;
  logic [NT-1:0]    in_valid;
  logic [WW-1:0]    in_warp_num;
  logic             in_freeze;
  logic             dcache_req_valid;
  logic             dcache_req_ready;
  logic [31:0]      dcache_req_addr;
  logic             dcache_req_we;
  logic [3:0]       dcache_req_byteen;
  logic [31:0]      dcache_req_wdata;
  logic             dcache_rsp_valid;
  logic [31:0]      dcache_rsp_data;
  logic [NT*32-1:0] out_alu_result;
  logic [4:0]       out_rd;
  logic [1:0]       out_wb;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [31:0]      out_PC_next;
  logic [NT-1:0]    out_valid;
  logic [WW-1:0]    out_warp_num;
  logic [NT*32-1:0] out_mem_result;
  logic             out_freeze;

  vx_mem_access_stage #(.NT(NT), .NW(NW)) dut (
    .clk(clk),
    .reset(reset),
    .in_alu_result(in_alu_result),
    .in_rs2_data(in_rs2_data),
    .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write),
    .in_rd(in_rd),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_wb(in_wb),
    .in_PC_next(in_PC_next),
    .in_valid(in_valid),
    .in_warp_num(in_warp_num),
    .in_freeze(in_freeze),
    .dcache_req_valid(dcache_req_valid),
    .dcache_req_ready(dcache_req_ready),
    .dcache_req_addr(dcache_req_addr),
    .dcache_req_we(dcache_req_we),
    .dcache_req_byteen(dcache_req_byteen),
    .dcache_req_wdata(dcache_req_wdata),
    .dcache_rsp_valid(dcache_rsp_valid),
    .dcache_rsp_data(dcache_rsp_data),
    .out_alu_result(out_alu_result),
    .out_rd(out_rd),
    .out_wb(out_wb),
    .out_rs1(out_rs1),
    .out_rs2(out_rs2),
    .out_PC_next(out_PC_next),
    .out_valid(out_valid),
    .out_warp_num(out_warp_num),
    .out_mem_result(out_mem_result),
    .out_freeze(out_freeze)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          lat;
  } req_t;

  req_t             req_q[$];
  logic [NT*32-1:0] res_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a[1:0])) & 32'hff;
    h = (w >> (16 * a[1])) & 32'hffff;
    case (f)
      3'd0: fmt = b[7] ? (b | 32'hffffff00) : b;
      3'd4: fmt = b;
      3'd1: fmt = h[15] ? (h | 32'hffff0000) : h;
      3'd5: fmt = h;
      default: fmt = w;
    endcase
  endfunction

  // dcache model: scoreboard check on every accepted request,
  // load responses after the latency stored in that entry
  initial begin
    req_t r;
    dcache_rsp_valid = 1'b0;
    dcache_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (dcache_req_valid && dcache_req_ready) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 0, 1);
        end else begin
          r = req_q.pop_front();
          check("req_addr", dcache_req_addr, r.addr);
          check("req_we", dcache_req_we, r.we);
          check("req_byteen", dcache_req_byteen, r.byteen);
          check("req_wdata", dcache_req_wdata, r.wdata);
          if (!r.we) begin
            @(posedge clk);
            repeat (r.lat - 1) @(posedge clk);
            #1;
            dcache_rsp_valid = 1'b1;
            dcache_rsp_data  = r.rsp;
            @(posedge clk);
            #1;
            dcache_rsp_valid = 1'b0;
            dcache_rsp_data  = '0;
          end
        end
      end
    end
  end

  task automatic nop();
    in_mem_read  = 3'd7;
    in_mem_write = 3'd7;
    in_valid     = 4'hf;
    in_freeze    = 1'b0;
  endtask

  task automatic push_req(input logic [2:0] rf,
                          input logic [2:0] wf,
                          input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [31:0] rsp,
                          input int lat);
    req_t r;
    r.addr = a & 32'hffff_fffc;
    r.rsp  = rsp;
    r.lat  = lat;
    if (rf != 3'd7) begin
      r.we = 1'b0;
      r.byteen = 4'hf;
      r.wdata = '0;
    end else begin
      r.we = 1'b1;
      case (wf)
        3'd0: begin
          r.wdata = {4{d[7:0]}};
          r.byteen = 4'(1 << a[1:0]);
        end
        3'd1: begin
          r.wdata = {2{d[15:0]}};
          r.byteen = a[1] ? 4'hc : 4'h3;
        end
        default: begin
          r.wdata = d;
          r.byteen = 4'hf;
        end
      endcase
    end
    req_q.push_back(r);
  endtask

  // called at posedge+1; returns at posedge+1 with a nop driven
  task automatic run_op(input string tag,
                        input logic [2:0] rf,
                        input logic [2:0] wf,
                        input logic [NT-1:0] vm,
                        input logic [NT*32-1:0] addrs,
                        input logic [NT*32-1:0] datas,
                        input logic [NT*32-1:0] rsps,
                        input int lat);
    logic [NT*32-1:0] er;
    int k;
    int fz;
    bit done;
    er = '0;
    k  = 0;
    for (int i = 0; i < NT; i++) begin
      if (vm[i]) begin
        k++;
        push_req(rf, wf, addrs[i*32 +: 32], datas[i*32 +: 32],
                 rsps[i*32 +: 32], lat);
        if (rf != 3'd7)
          er[i*32 +: 32] = fmt(rf, addrs[i*32 +: 32],
                               rsps[i*32 +: 32]);
      end
    end
    res_q.push_back(er);
    in_alu_result = addrs;
    in_rs2_data   = datas;
    in_mem_read   = rf;
    in_mem_write  = wf;
    in_valid      = vm;
    in_freeze     = 1'b0;
    fz   = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!out_freeze) begin
        done = 1;
      end else begin
        fz++;
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_timeout"}, done, 1);
    check({tag, "_result"}, out_mem_result, res_q.pop_front());
    if (rf != 3'd7) check({tag, "_freeze"}, fz, 1 + k * (1 + lat));
    else check({tag, "_freeze"}, fz, 1 + k);
    @(posedge clk);
    #1;
    nop();
  endtask

  logic [NT*32-1:0] a;
  logic [NT*32-1:0] d;
  logic [NT*32-1:0] r;

  initial begin
    reset            = 1'b1;
    dcache_req_ready = 1'b1;
    in_alu_result    = '0;
    in_rs2_data      = '0;
    in_rd            = 5'd3;
    in_rs1           = 5'd7;
    in_rs2           = 5'd9;
    in_wb            = 2'd1;
    in_PC_next       = 32'h0000_1004;
    in_warp_num      = 3'd5;
    nop();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", dcache_req_valid, 0);
    check("rst_mem_result", out_mem_result, 0);
    check("rst_freeze", out_freeze, 0);
    in_freeze = 1'b1;
    #1;
    check("rst_freeze_in", out_freeze, 1);
    in_freeze = 1'b0;
    reset = 1'b0;

    // ALU op: pure pass-through, no stall
    in_alu_result = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("alu_freeze", out_freeze, 0);
      check("alu_req", dcache_req_valid, 0);
      check("alu_mem", out_mem_result, 0);
    end
    check("alu_pass", out_alu_result, in_alu_result);
    check("alu_rd", out_rd, 5'd3);
    check("alu_pc", out_PC_next, 32'h0000_1004);
    check("alu_warp", out_warp_num, 3'd5);
    check("alu_valid", out_valid, 4'hf);

    // SW on lanes 0 and 2
    a = '0;
    d = '0;
    a[31:0]  = 32'h100;
    a[95:64] = 32'h208;
    d[31:0]  = 32'h1234_5678;
    d[95:64] = 32'h9abc_def0;
    run_op("sw2", 3'd7, 3'd2, 4'b0101, a, d, '0, 1);

    // LB lane 1, latency 3
    a = '0;
    r = '0;
    a[63:32] = 32'h103;
    r[63:32] = 32'h80FF_FF7F;
    run_op("lb", 3'd0, 3'd7, 4'b0010, a, '0, r, 3);

    // LHU lane 0
    a = '0;
    r = '0;
    a[31:0] = 32'h102;
    r[31:0] = 32'hBEEF_1234;
    run_op("lhu", 3'd5, 3'd7, 4'b0001, a, '0, r, 1);

    // SB lane 3
    a = '0;
    d = '0;
    a[127:96] = 32'h101;
    d[127:96] = 32'h0000_00AB;
    run_op("sb", 3'd7, 3'd0, 4'b1000, a, d, '0, 1);

    // SH at upper half, lanes 1 and 3
    a = '0;
    d = '0;
    a[63:32]  = 32'h222;
    a[127:96] = 32'h331;
    d[63:32]  = 32'hFFFF_A5C3;
    d[127:96] = 32'h0000_7E11;
    run_op("sh", 3'd7, 3'd1, 4'b1010, a, d, '0, 1);

    // LW all lanes, random words and addresses
    for (int i = 0; i < NT; i++) begin
      a[i*32 +: 32] = $urandom & 32'h0000_fffc;
      r[i*32 +: 32] = $urandom;
    end
    run_op("lw4", 3'd2, 3'd7, 4'hf, a, '0, r, 2);

    // LH signed, LBU mixed lanes
    for (int i = 0; i < NT; i++) begin
      a[i*32 +: 32] = 32'h400 + 32'(i);
      r[i*32 +: 32] = 32'h8001_F0F0 ^ 32'(i << 8);
    end
    run_op("lh", 3'd1, 3'd7, 4'b1011, a, '0, r, 1);
    run_op("lbu", 3'd4, 3'd7, 4'b0110, a, '0, r, 2);

    // memop with no active lanes: no stall, no request
    in_mem_read = 3'd2;
    in_valid    = 4'h0;
    #1;
    check("nolane_freeze", out_freeze, 0);
    @(posedge clk);
    #1;
    check("nolane_req", dcache_req_valid, 0);
    nop();

    // ready low for 5 cycles: fields stable, stall held
    dcache_req_ready = 1'b0;
    a = '0;
    d = '0;
    a[31:0] = 32'h41;
    d[31:0] = 32'h1122_3344;
    push_req(3'd7, 3'd2, 32'h41, 32'h1122_3344, '0, 1);
    res_q.push_back('0);
    in_alu_result = a;
    in_rs2_data   = d;
    in_mem_write  = 3'd2;
    in_valid      = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_valid", dcache_req_valid, 1);
      check("hold_addr", dcache_req_addr, 32'h40);
      check("hold_wdata", dcache_req_wdata, 32'h1122_3344);
      check("hold_byteen", dcache_req_byteen, 4'hf);
      check("hold_freeze", out_freeze, 1);
    end
    dcache_req_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_done", out_freeze, 0);
    check("hold_result", out_mem_result, res_q.pop_front());
    @(posedge clk);
    #1;
    nop();

    // reset while waiting for a load response
    push_req(3'd2, 3'd7, 32'h300, '0, 32'hDEAD_BEEF, 6);
    a = '0;
    a[127:96] = 32'h300;
    in_alu_result = a;
    in_mem_read   = 3'd2;
    in_valid      = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    check("wait_freeze", out_freeze, 1);
    check("wait_req", dcache_req_valid, 0);
    reset = 1'b1;
    nop();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("rstw_req", dcache_req_valid, 0);
      check("rstw_freeze", out_freeze, 0);
      check("rstw_mem", out_mem_result, 0);
    end

    // downstream freeze held while in DONE
    a = '0;
    r = '0;
    a[31:0] = 32'h10;
    r[31:0] = 32'hCAFE_F00D;
    push_req(3'd2, 3'd7, 32'h10, '0, 32'hCAFE_F00D, 1);
    res_q.push_back(r);
    in_alu_result = a;
    in_mem_read   = 3'd2;
    in_valid      = 4'b0001;
    in_freeze     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    r = res_q.pop_front();
    check("frz_result0", out_mem_result, r);
    check("frz_freeze0", out_freeze, 1);
    @(posedge clk);
    #1;
    check("frz_result1", out_mem_result, r);
    check("frz_freeze1", out_freeze, 1);
    in_freeze = 1'b0;
    #1;
    check("frz_release", out_freeze, 0);
    check("frz_result2", out_mem_result, r);
    @(posedge clk);
    #1;
    nop();
    #1;
    check("frz_idle_mem", out_mem_result, 0);
    check("frz_idle_freeze", out_freeze, 0);

    repeat (4) @(posedge clk);
    #1;
    check("req_q_left", req_q.size(), 0);
    check("res_q_left", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/vx_mem_access_stage.md
# vx_mem_access_stage

Memory stage of the SIMT pipeline, between the execute/memory pipeline register and the memory/writeback pipeline register. For load and store instructions it serialises per-thread accesses to the data cache, one lane at a time. It formats and sign-extends load data into a per-lane result vector and stalls the pipeline until every active lane has completed. Non-memory instructions pass straight through with no added cycles.

## Interface
- NT, 4, threads per warp
- NW, 8, warps; warp index width WW = $clog2(NW)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_alu_result  in  NT*32  per-lane ALU result; byte address for memory ops
- in_rs2_data  in  NT*32  per-lane store data
- in_mem_read  in  3  load funct3 (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU); 7 = none
- in_mem_write  in  3  store funct3 (0 SB, 1 SH, 2 SW); 7 = none
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_wb  in  2  writeback select
- in_PC_next  in  32  next PC
- in_valid  in  NT  active-lane mask
- in_warp_num  in  WW  warp id
- in_freeze  in  1  downstream stall
- dcache_req_valid  out  1  request valid
- dcache_req_ready  in  1  cache accepts request
- dcache_req_addr  out  32  word-aligned address
- dcache_req_we  out  1  1 = store
- dcache_req_byteen  out  4  byte enables
- dcache_req_wdata  out  32  store data, lane-replicated
- dcache_rsp_valid  in  1  load data valid
- dcache_rsp_data  in  32  load word
- out_alu_result, out_rd, out_wb, out_rs1, out_rs2, out_PC_next, out_valid, out_warp_num  out  as inputs  combinational pass-through
- out_mem_result  out  NT*32  formatted load data
- out_freeze  out  1  stall to upstream stages and the memory/writeback register

## Operation
- memop = (in_mem_read != 7) | (in_mem_write != 7).
- If in_mem_read != 7, in_mem_write is ignored.
- Upstream holds all inputs stable while out_freeze = 1.
- State registers: state (IDLE, REQ, WAIT, DONE), remaining[NT], mem_result_q[NT*32].
- Current lane = lowest set bit of remaining.
- IDLE: if memop & |in_valid, then remaining <= in_valid, mem_result_q <= 0, go to REQ. Otherwise stay in IDLE.
- REQ: dcache_req_valid = 1 for the current lane. On dcache_req_ready:
  - Load: go to WAIT.
  - Store: clear the lane's bit; go to DONE if no bits remain, else stay in REQ.
- WAIT: on dcache_rsp_valid, write the formatted data into the current lane of mem_result_q and clear the lane's bit. Go to DONE if no bits remain, else go to REQ.
- DONE: go to IDLE when in_freeze = 0.
- out_freeze = in_freeze | (IDLE & memop & |in_valid) | REQ | WAIT.
- out_mem_result = mem_result_q in DONE, else 0.
- A memop with in_valid = 0 behaves as a non-memory op: no requests, no stall.
- Address, with a = lane address:
  - dcache_req_addr = {a[31:2], 2'b00}.
  - Misaligned low bits are ignored: a[0] for halfword, a[1:0] for word.
- Stores:
  - SB: wdata = byte replicated ×4; byteen = 1 << a[1:0].
  - SH: wdata = halfword replicated ×2; byteen = a[1] ? 1100 : 0011.
  - SW: wdata = data; byteen = 1111.
- Loads:
  - dcache_req_we = 0; byteen = 1111.
  - LB/LBU: byte a[1:0], sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: full word.
- Inactive lanes read 0 in out_mem_result.
- When dcache_req_valid = 0, dcache_req_addr, dcache_req_wdata, dcache_req_byteen and dcache_req_we are 0.

## Timing
- Reset: state IDLE, remaining 0, mem_result_q 0.
  - dcache_req_valid = 0.
  - out_mem_result = 0.
  - out_freeze = in_freeze | (memop & |in_valid).
- Reset mid-operation abandons the outstanding access. A later dcache_rsp_valid is ignored.
- dcache_rsp_valid outside WAIT is ignored.
- At most one outstanding request. The response arrives no earlier than the cycle after acceptance.
- dcache_req_valid stays asserted with stable fields until accepted.
- Non-memory op: 0 added cycles; out_freeze = in_freeze.
- Store, k active lanes, ready always high: 1 IDLE + k REQ + 1 DONE, so out_freeze is high for k+1 cycles.
- Load: each lane takes 1 REQ cycle plus WAIT cycles until the response.
- Result visibility:
  - The memory/writeback register captures in the first DONE cycle with in_freeze = 0.
  - The next instruction appears in the following cycle.

## Test plan
- ALU op, in_valid = 1111, in_freeze = 0 → out_freeze = 0 throughout; no requests; out_mem_result = 0; out_alu_result equals in_alu_result.
- SW, lanes 0 and 2, addrs 0x100/0x208, ready = 1 → two requests in consecutive cycles (0x100 then 0x208, byteen 1111); out_freeze high 3 cycles; DONE on the 4th cycle.
- LB, lane 1, addr 0x103, rsp_data 0x80FF_FF7F with 3-cycle response latency → byte is 0x80; lane 1 result = 0xFFFFFF80; other lanes 0.
- LHU at 0x102, rsp 0xBEEF1234 → result 0x0000BEEF.
- SB at 0x101, data 0xAB → wdata 0xABABABAB, byteen 0010.
- Ready held low 5 cycles → req fields stable, out_freeze held; reset asserted while in WAIT → state IDLE, a later rsp_valid is ignored, out_mem_result = 0.
- in_freeze = 1 in DONE for 2 cycles → state stays in DONE, out_mem_result holds, out_freeze = 1; one cycle after in_freeze drops the state is IDLE.
